// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT frame scheduler.
package fft_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConfig,
        StStream
    } fft_state_e;

    localparam int unsigned FWD_INV_BIT       = 0;
    localparam int unsigned DEFAULT_NFFT_LOG2 = 6;
    localparam int unsigned DEFAULT_DW        = 8;

endpackage

// File: rtl/fft_tag_fifo.sv
// Small FIFO of requester IDs for frames in flight through the FFT core.
module fft_tag_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_en, pop_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));
    // Pop on empty is dropped; push on full is allowed only if a pop frees the slot.
    assign pop_en  = pop_i & ~empty_o;
    assign push_en = push_i & (~full_o | pop_en);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_en) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (pop_en) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        unique case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Round-robin scheduler sharing one streaming FFT core between two frame requesters.
module fft_frame_scheduler
    import fft_pkg::*;
#(
    parameter int unsigned NFFT_LOG2 = DEFAULT_NFFT_LOG2,
    parameter int unsigned DW        = DEFAULT_DW,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic [2*DW-1:0] s0_tdata,
    input  logic            s0_tvalid,
    input  logic            s0_inverse,
    output logic            s0_tready,
    input  logic [2*DW-1:0] s1_tdata,
    input  logic            s1_tvalid,
    input  logic            s1_inverse,
    output logic            s1_tready,
    output logic [7:0]      cfg_tdata,
    output logic            cfg_tvalid,
    input  logic            cfg_tready,
    output logic [2*DW-1:0] fft_tdata,
    output logic            fft_tvalid,
    input  logic            fft_tready,
    output logic            fft_tlast,
    input  logic            res_tvalid,
    input  logic            res_tready,
    input  logic            res_tlast,
    output logic            res_tag,
    output logic            res_tag_valid,
    output logic            frame_done
);

    localparam logic [NFFT_LOG2-1:0] LastBeat = '1;

    fft_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 fwd_inv_q, fwd_inv_d;
    logic                 rr_q, rr_d;
    logic [NFFT_LOG2-1:0] cnt_q, cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic                 grant;
    logic                 tag_push, tag_pop, tag_full, tag_empty;

    assign tag_pop       = res_tvalid & res_tready & res_tlast;
    assign res_tag_valid = ~tag_empty;
    assign frame_done    = frame_done_q;

    fft_tag_fifo #(
        .Width(1),
        .Depth(TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i  (clk_in),
        .rst_ni (rst_n),
        .push_i (tag_push),
        .wdata_i(owner_q),
        .pop_i  (tag_pop),
        .rdata_o(res_tag),
        .full_o (tag_full),
        .empty_o(tag_empty)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        fwd_inv_d    = fwd_inv_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        grant        = 1'b0;
        tag_push     = 1'b0;
        cfg_tvalid   = 1'b0;
        cfg_tdata    = '0;
        fft_tdata    = '0;
        fft_tvalid   = 1'b0;
        fft_tlast    = 1'b0;
        s0_tready    = 1'b0;
        s1_tready    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!tag_full && (s0_tvalid || s1_tvalid)) begin
                    // rr_q holds the last owner, so a tie goes to the other requester.
                    grant     = (s0_tvalid && s1_tvalid) ? ~rr_q : s1_tvalid;
                    owner_d   = grant;
                    fwd_inv_d = grant ? ~s1_inverse : ~s0_inverse;
                    state_d   = StConfig;
                end
            end
            StConfig: begin
                cfg_tvalid             = 1'b1;
                cfg_tdata[FWD_INV_BIT] = fwd_inv_q;
                if (cfg_tready) begin
                    tag_push = 1'b1;
                    state_d  = StStream;
                end
            end
            StStream: begin
                fft_tdata  = owner_q ? s1_tdata : s0_tdata;
                fft_tvalid = owner_q ? s1_tvalid : s0_tvalid;
                fft_tlast  = (cnt_q == LastBeat);
                s0_tready  = ~owner_q & fft_tready;
                s1_tready  = owner_q & fft_tready;
                if (fft_tvalid && fft_tready) begin
                    cnt_d = cnt_q + NFFT_LOG2'(1);
                    if (fft_tlast) begin
                        frame_done_d = 1'b1;
                        rr_d         = owner_q;
                        state_d      = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            fwd_inv_q    <= 1'b0;
            rr_q         <= 1'b1;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            fwd_inv_q    <= fwd_inv_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler with 8-point frames and a 2-deep tag FIFO.
module tb_fft_frame_scheduler;

    localparam int NL = 3;
    localparam int DW = 8;
    localparam int TD = 2;

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic [2*DW-1:0] s0_tdata, s1_tdata, fft_tdata;
    logic          s0_tvalid, s0_inverse, s0_tready;
    logic          s1_tvalid, s1_inverse, s1_tready;
    logic [7:0]    cfg_tdata;
    logic          cfg_tvalid, cfg_tready;
    logic          fft_tvalid, fft_tready, fft_tlast;
    logic          res_tvalid, res_tready, res_tlast;
    logic          res_tag, res_tag_valid, frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    fft_frame_scheduler #(
        .NFFT_LOG2(NL),
        .DW       (DW),
        .TAG_DEPTH(TD)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .s0_tdata     (s0_tdata),
        .s0_tvalid    (s0_tvalid),
        .s0_inverse   (s0_inverse),
        .s0_tready    (s0_tready),
        .s1_tdata     (s1_tdata),
        .s1_tvalid    (s1_tvalid),
        .s1_inverse   (s1_inverse),
        .s1_tready    (s1_tready),
        .cfg_tdata    (cfg_tdata),
        .cfg_tvalid   (cfg_tvalid),
        .cfg_tready   (cfg_tready),
        .fft_tdata    (fft_tdata),
        .fft_tvalid   (fft_tvalid),
        .fft_tready   (fft_tready),
        .fft_tlast    (fft_tlast),
        .res_tvalid   (res_tvalid),
        .res_tready   (res_tready),
        .res_tlast    (res_tlast),
        .res_tag      (res_tag),
        .res_tag_valid(res_tag_valid),
        .frame_done   (frame_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int r, input int b);
        logic [7:0] rb;
        logic [7:0] bb;
        rb = 8'(r);
        bb = 8'(b);
        return {rb[3:0], bb[3:0], bb ^ 8'hA5};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cfg_tvalid"}, cfg_tvalid, 1'b0);
        check_eq({tag, "_cfg_tdata"}, cfg_tdata, 8'h00);
        check_eq({tag, "_fft_tvalid"}, fft_tvalid, 1'b0);
        check_eq({tag, "_fft_tlast"}, fft_tlast, 1'b0);
        check_eq({tag, "_s0_tready"}, s0_tready, 1'b0);
        check_eq({tag, "_s1_tready"}, s1_tready, 1'b0);
        check_eq({tag, "_frame_done"}, frame_done, 1'b0);
        check_eq({tag, "_res_tag"}, res_tag, 1'b0);
        check_eq({tag, "_res_tag_valid"}, res_tag_valid, 1'b0);
    endtask

    // Called just after a negedge; returns just after the negedge following the last beat.
    task automatic do_frame(input int req, input logic [7:0] exp_cfg, input bit toggle,
                            input int abort_at);
        int beats;
        int cyc;
        bit got_cfg;
        logic own_rdy, other_rdy;
        beats   = 0;
        cyc     = 0;
        got_cfg = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (cfg_tvalid) begin
                got_cfg = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        check_eq("cfg_seen", got_cfg, 1'b1);
        if (!got_cfg) return;
        check_eq("cfg_tdata", cfg_tdata, exp_cfg);
        check_eq("cfg_no_fft_tvalid", fft_tvalid, 1'b0);
        @(negedge clk_in);
        while (beats < 8 && cyc < 40) begin
            if (beats == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                fft_tready = 1'b1;
                return;
            end
            fft_tready = toggle ? cyc[0] : 1'b1;
            s0_tdata   = pat(0, beats);
            s1_tdata   = pat(1, beats);
            #1;
            own_rdy   = (req == 1) ? s1_tready : s0_tready;
            other_rdy = (req == 1) ? s0_tready : s1_tready;
            check_eq("fft_tvalid", fft_tvalid, 1'b1);
            check_eq("fft_tdata", fft_tdata, pat(req, beats));
            check_eq("fft_tlast", fft_tlast, beats == 7);
            check_eq("owner_tready", own_rdy, fft_tready);
            check_eq("other_tready", other_rdy, 1'b0);
            if (fft_tready) beats++;
            cyc++;
            @(negedge clk_in);
        end
        check_eq("beats", beats, 8);
        #1;
        check_eq("frame_done", frame_done, 1'b1);
        check_eq("idle_fft_tvalid", fft_tvalid, 1'b0);
        check_eq("idle_cfg_tvalid", cfg_tvalid, 1'b0);
        fft_tready = 1'b1;
    endtask

    task automatic pop_result(input logic last);
        res_tvalid = 1'b1;
        res_tready = 1'b1;
        res_tlast  = last;
        @(negedge clk_in);
        res_tvalid = 1'b0;
        res_tready = 1'b0;
        res_tlast  = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        s0_tdata   = '0;
        s1_tdata   = '0;
        s0_tvalid  = 1'b0;
        s1_tvalid  = 1'b0;
        s0_inverse = 1'b0;
        s1_inverse = 1'b1;
        cfg_tready = 1'b1;
        fft_tready = 1'b1;
        res_tvalid = 1'b0;
        res_tready = 1'b0;
        res_tlast  = 1'b0;
        #3;
        check_reset_outputs("reset");

        // Single forward frame from requester 0.
        @(negedge clk_in);
        rst_n     = 1'b1;
        s0_tvalid = 1'b1;
        do_frame(0, 8'h01, 1'b0, 8);
        s0_tvalid = 1'b0;
        check_eq("tag0_valid", res_tag_valid, 1'b1);
        check_eq("tag0", res_tag, 1'b0);

        // Inverse frame from requester 1 under toggling backpressure; fills the FIFO.
        s1_tvalid = 1'b1;
        do_frame(1, 8'h00, 1'b1, 8);
        s1_tvalid = 1'b0;
        check_eq("head_after_two", res_tag, 1'b0);

        // FIFO full: request must wait until a result frame completes.
        s0_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            #1;
            check_eq("full_hold_cfg", cfg_tvalid, 1'b0);
            check_eq("full_hold_rdy", s0_tready, 1'b0);
        end
        pop_result(1'b0);
        check_eq("no_pop_without_tlast", res_tag, 1'b0);
        check_eq("full_still_idle", cfg_tvalid, 1'b0);
        pop_result(1'b1);
        check_eq("pop_head", res_tag, 1'b1);
        do_frame(0, 8'h01, 1'b0, 8);
        s0_tvalid = 1'b0;
        check_eq("order_head1", res_tag, 1'b1);
        pop_result(1'b1);
        check_eq("order_head2", res_tag, 1'b0);
        check_eq("order_valid2", res_tag_valid, 1'b1);
        pop_result(1'b1);
        check_eq("drained_valid", res_tag_valid, 1'b0);
        check_eq("drained_tag", res_tag, 1'b0);
        pop_result(1'b1);
        check_eq("empty_pop_valid", res_tag_valid, 1'b0);
        s1_tvalid = 1'b1;
        do_frame(1, 8'h00, 1'b0, 8);
        s1_tvalid = 1'b0;
        check_eq("after_empty_pop_tag", res_tag, 1'b1);
        check_eq("after_empty_pop_valid", res_tag_valid, 1'b1);

        // Reset after beat 4 abandons the frame and its tag.
        s0_tvalid = 1'b1;
        do_frame(0, 8'h01, 1'b0, 4);
        @(negedge clk_in);
        rst_n = 1'b1;
        do_frame(0, 8'h01, 1'b0, 8);
        s0_tvalid = 1'b0;
        check_eq("post_abort_tag", res_tag, 1'b0);
        check_eq("post_abort_valid", res_tag_valid, 1'b1);

        // Contention from a fresh reset: order 0,1,0,1 with results drained continuously.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset2");
        @(negedge clk_in);
        rst_n      = 1'b1;
        res_tvalid = 1'b1;
        res_tready = 1'b1;
        res_tlast  = 1'b1;
        s0_tvalid  = 1'b1;
        s1_tvalid  = 1'b1;
        do_frame(0, 8'h01, 1'b0, 8);
        do_frame(1, 8'h00, 1'b0, 8);
        do_frame(0, 8'h01, 1'b0, 8);
        do_frame(1, 8'h00, 1'b0, 8);
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_scheduler.md
FFT_FRAME_SCHEDULER -- requirements
Module: fft_frame_scheduler

Interface
REQ-001 Parameters SHALL be:
- NFFT_LOG2, 6, log2 of FFT points per frame (N = 2^NFFT_LOG2)
- DW, 8, signed bits per real/imag sample
- TAG_DEPTH, 4, depth of the in-flight frame tag FIFO (power of 2)
REQ-002 Ports SHALL be:
- clk_in, in, 1, single clock; all logic on rising edge
- rst_n, in, 1, asynchronous active-low reset
- s0_tdata, in, 2*DW, requester 0 sample {re, im}
- s0_tvalid, in, 1, requester 0 sample valid / frame pending
- s0_inverse, in, 1, requester 0 wants inverse FFT; sampled at grant
- s0_tready, out, 1, requester 0 beat accepted
- s1_tdata / s1_tvalid / s1_inverse / s1_tready: same as requester 0, for requester 1
- cfg_tdata, out, 8, FFT config word {7'b0, fwd_inv}
- cfg_tvalid, out, 1, config word valid
- cfg_tready, in, 1, FFT accepts config
- fft_tdata, out, 2*DW, muxed sample to FFT
- fft_tvalid, out, 1, muxed valid
- fft_tready, in, 1, FFT accepts sample
- fft_tlast, out, 1, last sample of frame
- res_tvalid, in, 1, FFT result valid (monitored)
- res_tready, in, 1, downstream accepts result (monitored)
- res_tlast, in, 1, last result beat of frame (monitored)
- res_tag, out, 1, requester ID owning the current result frame
- res_tag_valid, out, 1, tag FIFO not empty
- frame_done, out, 1, one-cycle pulse when the input frame's last beat is accepted

Function
REQ-003 FSM states SHALL be IDLE, CONFIG, STREAM.
REQ-004 IDLE: if tag FIFO not full and any sX_tvalid=1, grant on next edge and go to CONFIG; if full, stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; the pointer resets to 1, so requester 0 wins the first tie.
REQ-006 Grant SHALL latch owner ID and fwd_inv = ~sX_inverse.
REQ-007 CONFIG: cfg_tvalid=1, cfg_tdata stable until cfg_tvalid&cfg_tready; on that edge push owner ID into the tag FIFO, go to STREAM.
REQ-008 STREAM: fft_tdata/fft_tvalid = owner's tdata/tvalid; owner sX_tready = fft_tready; non-owner tready=0; combinational mux with no added latency.
REQ-009 Beat counter (NFFT_LOG2 bits) SHALL increment on fft_tvalid&fft_tready only; fft_tlast=1 when count==N-1 in STREAM.
REQ-010 On the last-beat handshake: counter wraps to 0, frame_done pulses next cycle, RR pointer updates to owner, FSM goes to IDLE (one idle cycle minimum between frames).
REQ-011 Tag FIFO SHALL pop on res_tvalid&res_tready&res_tlast; res_tag = head, res_tag_valid = ~empty.
REQ-012 Simultaneous push and pop SHALL both take effect; occupancy is unchanged, including when full.
REQ-013 A pop while empty SHALL be ignored, with no pointer change.
REQ-014 Outside STREAM, fft_tvalid=0, fft_tlast=0, both sX_tready=0.

Reset
REQ-015 Asserting rst_n low SHALL immediately force: IDLE, counter=0, tag FIFO empty, RR pointer=1, cfg_tvalid=0, cfg_tdata=8'h00, fft_tvalid=0, fft_tlast=0, s0/s1_tready=0, frame_done=0, res_tag=0, res_tag_valid=0.
REQ-016 Reset asserted mid-frame SHALL abandon the frame; no frame_done and no tag are retained.
REQ-017 Deassertion SHALL be synchronized externally; the first grant can occur on the first edge after release.

Structure
REQ-018 Shared package fft_pkg SHALL hold the state enum, the config bit position FWD_INV_BIT=0, and the default NFFT_LOG2 and DW.
REQ-019 The tag FIFO SHALL be a sub-module fft_tag_fifo (width 1, depth TAG_DEPTH, full/empty flags).

Verification (NFFT_LOG2=3, TAG_DEPTH=2)
REQ-020 Single frame: s0_tvalid=1, s0_inverse=0, cfg_tready=1, fft_tready=1 -> cfg_tdata=8'h01 for 1 cycle, 8 beats forwarded, fft_tlast on 8th, frame_done pulse, tag 0 pushed.
REQ-021 Contention: s0 and s1 valid continuously, s1_inverse=1 -> frame order 0,1,0,1; cfg_tdata 01,00,01,00.
REQ-022 Backpressure: fft_tready toggles every cycle -> exactly 8 accepted beats, tlast only on the 8th accepted beat, no data loss.
REQ-023 Tag FIFO full: two frames done, no result pops -> third request stays IDLE; one res_tlast handshake -> grant proceeds, res_tag follows push order.
REQ-024 Reset mid-frame: rst_n low after beat 4 -> all outputs at reset values immediately; next frame's tlast on its 8th beat.
